bsk_ntw_client: RTL and testbench
=================================

Name: bsk_ntw_client

Overview:
- Receiving end of the BSK broadcast bus driven by the bsk_ntw_server instances.
- Captures one complete BSK batch into a 2-slot ping-pong buffer, then streams it beat by beat to the NTT processing path over a valid/ready interface.
- Checks that the bus protocol is respected and flags violations on a registered error vector.

Parameters:
- OP_W, 32, coefficient width.
- COEF_NB, 8, coefficients per broadcast beat (BSK_DIST_COEF_NB).
- UNIT_NB, 4, units per group.
- GROUP_NB, 4, groups per batch. Batch length is BEAT_NB = UNIT_NB*GROUP_NB beats.
- BR_LOOP_W, 10, br_loop field width.
- Derived localparams: UNIT_W = $clog2(UNIT_NB), GROUP_W = $clog2(GROUP_NB), BEAT_W = $clog2(BEAT_NB).

Ports:
- clk  in  1  clock.
- s_rst  in  1  synchronous reset, active-high.
- srv_bdc_bsk  in  COEF_NB*OP_W  broadcast coefficients (OR of all servers).
- srv_bdc_avail  in  COEF_NB  per-coefficient valid.
- srv_bdc_unit  in  UNIT_W  unit index of beat.
- srv_bdc_group  in  GROUP_W  group index of beat.
- srv_bdc_br_loop  in  BR_LOOP_W  br_loop of beat.
- ntt_bsk  out  COEF_NB*OP_W  coefficients to NTT.
- ntt_vld  out  1  beat valid.
- ntt_rdy  in  1  NTT accepts beat.
- ntt_br_loop  out  BR_LOOP_W  br_loop of batch being read.
- ntt_last  out  1  last beat of batch.
- error  out  4  {err_partial, err_brloop, err_seq, err_ovf}, 1-cycle pulses.

Behaviour:
- Beat present: in_beat = srv_bdc_avail[0].
- err_partial: raised when srv_bdc_avail is neither all-0 nor all-1. A partial beat is treated as a beat using bit 0.
- Write side:
  - Registers wp (slot pointer), wcnt (BEAT_W bits), full[1:0], slot_br_loop[2].
  - On in_beat with full[wp]=0: write buffer[wp][group*UNIT_NB+unit]; increment wcnt.
  - First beat of a batch (wcnt=0) latches slot_br_loop[wp].
  - When wcnt reaches BEAT_NB-1 on a beat: set full[wp], toggle wp, wcnt←0.
- Write-side checks:
  - err_seq: received {group,unit} ≠ {wcnt/UNIT_NB, wcnt%UNIT_NB}. The data is still written at the received address.
  - err_brloop: br_loop ≠ latched slot_br_loop on any beat with wcnt≠0.
  - err_ovf: in_beat while full[wp]=1. The beat is dropped and no counters change.
- Read side:
  - Registers rp, rcnt.
  - ntt_vld = full[rp].
  - ntt_bsk = buffer[rp][rcnt], combinational read with 0 latency from ntt_vld.
  - ntt_br_loop = slot_br_loop[rp].
  - ntt_last = ntt_vld & (rcnt==BEAT_NB-1).
  - When ntt_vld is 0, ntt_bsk, ntt_br_loop and ntt_last are driven 0.
  - On ntt_vld&ntt_rdy: rcnt++. If ntt_last: clear full[rp], toggle rp, rcnt←0.
- Simultaneous events:
  - Write completing slot A and read releasing slot B in the same cycle: both take effect.
  - Write completing slot X and a read of X in the same cycle are impossible, since writes only target non-full slots.
  - A freed slot is writable in the cycle after release. A beat arriving in the release cycle itself gets err_ovf.
- ntt_vld may rise the cycle after the last write beat (full set on that edge). Latency from last input beat to ntt_vld is 1 cycle.
- Reset:
  - Clears wp, rp, wcnt, rcnt, full and error.
  - After reset: ntt_vld=0, ntt_last=0, ntt_bsk=0, ntt_br_loop=0, error=0.
  - Buffer contents and slot_br_loop are not reset.
  - Reset mid-batch discards partial and full slots. The next beat is treated as a batch start.
- Errors are registered with 1-cycle latency from the offending beat. They are not sticky.

Test Plan:
1. Reset, then 16 in-order beats with br_loop=5 and data=beat index replicated. Required: ntt_vld rises 1 cycle after beat 15; with ntt_rdy=1, 16 beats out in order; ntt_last on beat 15; ntt_br_loop=5; error=0.
2. Three back-to-back batches (br_loop 1,2,3) with ntt_rdy=0. Required: batches 1 and 2 fill both slots; first beat of batch 3 gives err_ovf=1 for that beat; draining yields batches 1 and 2 intact.
3. Batch with beats 4 and 5 swapped (unit 0/1 of group 1). Required: err_seq pulses twice; read-out order is still the address order, i.e. data correct.
4. Batch with br_loop=7 except beat 9 carrying br_loop=8. Required: err_brloop pulses once, 1 cycle after beat 9; ntt_br_loop=7.
5. Beat with srv_bdc_avail=8'h0F. Required: err_partial=1; the beat is counted.
6. Assert s_rst after 6 beats, then send a full batch. Required: only the new batch is read out, 16 beats, with all outputs 0 during reset.

Source files
------------

// File: rtl/bsk_ntw_client.sv
// BSK broadcast bus client: captures one batch into a 2-slot ping-pong buffer,
// streams it to the NTT path and flags bus protocol violations.
module bsk_ntw_client #(
    parameter  int OP_W      = 32,
    parameter  int COEF_NB   = 8,
    parameter  int UNIT_NB   = 4,
    parameter  int GROUP_NB  = 4,
    parameter  int BR_LOOP_W = 10,
    localparam int UNIT_W    = $clog2(UNIT_NB),
    localparam int GROUP_W   = $clog2(GROUP_NB),
    localparam int BEAT_NB   = UNIT_NB * GROUP_NB,
    localparam int BEAT_W    = $clog2(BEAT_NB)
) (
    input  logic                      clk,
    input  logic                      s_rst,
    input  logic [COEF_NB*OP_W-1:0]   srv_bdc_bsk,
    input  logic [COEF_NB-1:0]        srv_bdc_avail,
    input  logic [UNIT_W-1:0]         srv_bdc_unit,
    input  logic [GROUP_W-1:0]        srv_bdc_group,
    input  logic [BR_LOOP_W-1:0]      srv_bdc_br_loop,
    output logic [COEF_NB*OP_W-1:0]   ntt_bsk,
    output logic                      ntt_vld,
    input  logic                      ntt_rdy,
    output logic [BR_LOOP_W-1:0]      ntt_br_loop,
    output logic                      ntt_last,
    output logic [3:0]                error
);

    localparam int BSK_W = COEF_NB * OP_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEAT_NB - 1);

    logic [BSK_W-1:0]     buffer [2][BEAT_NB];
    logic [BR_LOOP_W-1:0] slot_br_loop [2];

    logic              wp;
    logic              rp;
    logic [BEAT_W-1:0] wcnt;
    logic [BEAT_W-1:0] rcnt;
    logic [1:0]        full;
    logic [1:0]        full_nxt;

    logic              in_beat;
    logic              wr_en;
    logic              wr_last;
    logic              rd_fire;
    logic              rd_last;
    logic [BEAT_W-1:0] wr_addr;
    logic              err_partial;
    logic              err_brloop;
    logic              err_seq;
    logic              err_ovf;

    // A partial beat still counts as a beat, keyed on coefficient 0.
    assign in_beat = srv_bdc_avail[0];
    assign wr_en   = in_beat && !full[wp];
    assign wr_last = wcnt == LAST_BEAT;
    assign wr_addr = BEAT_W'(srv_bdc_group) * BEAT_W'(UNIT_NB) + BEAT_W'(srv_bdc_unit);

    assign err_partial = (|srv_bdc_avail) && !(&srv_bdc_avail);
    assign err_ovf     = in_beat && full[wp];
    assign err_seq     = wr_en && (wr_addr != wcnt);
    assign err_brloop  = wr_en && (wcnt != '0) && (srv_bdc_br_loop != slot_br_loop[wp]);

    // ntt_vld/ntt_rdy: a beat transfers on any cycle where both are high;
    // ntt_vld never depends on ntt_rdy and the beat is held stable until taken.
    assign rd_fire = ntt_vld && ntt_rdy;
    assign rd_last = ntt_last;

    always_comb begin
        ntt_vld     = full[rp];
        ntt_last    = ntt_vld && (rcnt == LAST_BEAT);
        ntt_bsk     = ntt_vld ? buffer[rp][rcnt] : '0;
        ntt_br_loop = ntt_vld ? slot_br_loop[rp] : '0;
    end

    // Write completion and read release always target different slots.
    always_comb begin
        full_nxt = full;
        if (wr_en && wr_last) full_nxt[wp] = 1'b1;
        if (rd_fire && rd_last) full_nxt[rp] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
            full  <= '0;
            error <= '0;
        end else begin
            error <= {err_partial, err_brloop, err_seq, err_ovf};
            full  <= full_nxt;
            if (wr_en) begin
                if (wr_last) begin
                    wcnt <= '0;
                    wp   <= ~wp;
                end else begin
                    wcnt <= wcnt + BEAT_W'(1);
                end
            end
            if (rd_fire) begin
                if (rd_last) begin
                    rcnt <= '0;
                    rp   <= ~rp;
                end else begin
                    rcnt <= rcnt + BEAT_W'(1);
                end
            end
        end
    end

    // Payload storage carries no reset; it is only visible through full[].
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wp][wr_addr] <= srv_bdc_bsk;
            if (wcnt == '0) slot_br_loop[wp] <= srv_bdc_br_loop;
        end
    end

endmodule

// File: tb/tb_bsk_ntw_client.sv
// Directed bench for bsk_ntw_client: batch capture, ping-pong overflow,
// sequence/br_loop/partial errors and mid-batch reset.
module tb_bsk_ntw_client;

    localparam int OP_W      = 32;
    localparam int COEF_NB   = 8;
    localparam int BR_LOOP_W = 10;
    localparam int BSK_W     = OP_W * COEF_NB;

    logic                 clk = 1'b0;
    logic                 s_rst;
    logic [BSK_W-1:0]     srv_bdc_bsk;
    logic [COEF_NB-1:0]   srv_bdc_avail;
    logic [1:0]           srv_bdc_unit;
    logic [1:0]           srv_bdc_group;
    logic [BR_LOOP_W-1:0] srv_bdc_br_loop;
    logic [BSK_W-1:0]     ntt_bsk;
    logic                 ntt_vld;
    logic                 ntt_rdy;
    logic [BR_LOOP_W-1:0] ntt_br_loop;
    logic                 ntt_last;
    logic [3:0]           error;

    int checks = 0;
    int errors = 0;
    logic [BSK_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    bsk_ntw_client dut (
        .clk             (clk),
        .s_rst           (s_rst),
        .srv_bdc_bsk     (srv_bdc_bsk),
        .srv_bdc_avail   (srv_bdc_avail),
        .srv_bdc_unit    (srv_bdc_unit),
        .srv_bdc_group   (srv_bdc_group),
        .srv_bdc_br_loop (srv_bdc_br_loop),
        .ntt_bsk         (ntt_bsk),
        .ntt_vld         (ntt_vld),
        .ntt_rdy         (ntt_rdy),
        .ntt_br_loop     (ntt_br_loop),
        .ntt_last        (ntt_last),
        .error           (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BSK_W-1:0] obs, input logic [BSK_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BSK_W-1:0] rep(input logic [31:0] v);
        return {COEF_NB{v}};
    endfunction

    task automatic send_beat(input logic [1:0] g, input logic [1:0] u, input logic [BR_LOOP_W-1:0] br,
                             input logic [31:0] d, input logic [COEF_NB-1:0] av);
        srv_bdc_group   = g;
        srv_bdc_unit    = u;
        srv_bdc_br_loop = br;
        srv_bdc_bsk     = rep(d);
        srv_bdc_avail   = av;
        tick();
        srv_bdc_avail   = '0;
        srv_bdc_bsk     = '0;
        srv_bdc_br_loop = '0;
        srv_bdc_group   = '0;
        srv_bdc_unit    = '0;
    endtask

    task automatic beat_chk(input int pos, input logic [BR_LOOP_W-1:0] br, input logic [31:0] d,
                            input logic [COEF_NB-1:0] av, input logic [3:0] exp_err, input string tag);
        send_beat(2'(pos / 4), 2'(pos % 4), br, d, av);
        chk($sformatf("%s err beat %0d", tag, pos), BSK_W'(error), BSK_W'(exp_err));
    endtask

    task automatic send_batch(input logic [BR_LOOP_W-1:0] br, input logic [31:0] base, input string tag);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(rep(base + 32'(i)));
            beat_chk(i, br, base + 32'(i), '1, 4'b0000, tag);
        end
    endtask

    task automatic drain(input logic [BR_LOOP_W-1:0] br, input string tag);
        logic [BSK_W-1:0] e;
        for (int i = 0; i < 16; i++) begin
            for (int w = 0; w < 32 && ntt_vld !== 1'b1; w++) tick();
            chk($sformatf("%s vld %0d", tag, i), BSK_W'(ntt_vld), BSK_W'(1'b1));
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk($sformatf("%s data %0d", tag, i), ntt_bsk, e);
            chk($sformatf("%s last %0d", tag, i), BSK_W'(ntt_last), BSK_W'(i == 15));
            chk($sformatf("%s br_loop %0d", tag, i), BSK_W'(ntt_br_loop), BSK_W'(br));
            ntt_rdy = 1'b1;
            tick();
            ntt_rdy = 1'b0;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " vld"}, BSK_W'(ntt_vld), '0);
        chk({tag, " last"}, BSK_W'(ntt_last), '0);
        chk({tag, " bsk"}, ntt_bsk, '0);
        chk({tag, " br_loop"}, BSK_W'(ntt_br_loop), '0);
        chk({tag, " error"}, BSK_W'(error), '0);
    endtask

    initial begin
        s_rst           = 1'b1;
        srv_bdc_bsk     = '0;
        srv_bdc_avail   = '0;
        srv_bdc_unit    = '0;
        srv_bdc_group   = '0;
        srv_bdc_br_loop = '0;
        ntt_rdy         = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        s_rst = 1'b0;
        tick();

        // 1: single in-order batch, data = beat index
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(rep(32'(i)));
            beat_chk(i, 10'd5, 32'(i), '1, 4'b0000, "t1");
            if (i < 15) chk($sformatf("t1 vld early %0d", i), BSK_W'(ntt_vld), '0);
        end
        chk("t1 vld rise", BSK_W'(ntt_vld), BSK_W'(1'b1));
        drain(10'd5, "t1");
        chk("t1 vld after", BSK_W'(ntt_vld), '0);

        // 2: two batches fill both slots, third batch start overflows
        send_batch(10'd1, 32'h100, "t2a");
        send_batch(10'd2, 32'h200, "t2b");
        chk("t2 vld full", BSK_W'(ntt_vld), BSK_W'(1'b1));
        beat_chk(0, 10'd3, 32'h300, '1, 4'b0001, "t2 ovf");
        drain(10'd1, "t2a");
        drain(10'd2, "t2b");
        chk("t2 vld after", BSK_W'(ntt_vld), '0);

        // 3: beats 4 and 5 swapped on the bus
        for (int i = 0; i < 16; i++) begin
            int a;
            a = (i == 4) ? 5 : (i == 5) ? 4 : i;
            exp_q.push_back(rep(32'h400 + 32'(i)));
            beat_chk(a, 10'd4, 32'h400 + 32'(a), '1, (i == 4 || i == 5) ? 4'b0010 : 4'b0000, "t3");
        end
        drain(10'd4, "t3");

        // 4: beat 9 carries a different br_loop
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(rep(32'h500 + 32'(i)));
            beat_chk(i, (i == 9) ? 10'd8 : 10'd7, 32'h500 + 32'(i), '1,
                     (i == 9) ? 4'b0100 : 4'b0000, "t4");
        end
        drain(10'd7, "t4");

        // 5: first beat only partially valid, still counted
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(rep(32'h600 + 32'(i)));
            beat_chk(i, 10'd9, 32'h600 + 32'(i), (i == 0) ? 8'h0F : 8'hFF,
                     (i == 0) ? 4'b1000 : 4'b0000, "t5");
        end
        chk("t5 vld rise", BSK_W'(ntt_vld), BSK_W'(1'b1));
        drain(10'd9, "t5");

        // 6: reset with one full slot and a partial batch in flight
        send_batch(10'd11, 32'h700, "t6a");
        for (int i = 0; i < 6; i++) beat_chk(i, 10'd10, 32'h780 + 32'(i), '1, 4'b0000, "t6p");
        chk("t6 vld pre-reset", BSK_W'(ntt_vld), BSK_W'(1'b1));
        s_rst = 1'b1;
        tick();
        chk_idle_outputs("t6 rst0");
        tick();
        chk_idle_outputs("t6 rst1");
        s_rst = 1'b0;
        exp_q.delete();
        tick();
        chk("t6 vld post-reset", BSK_W'(ntt_vld), '0);
        send_batch(10'd12, 32'h800, "t6b");
        drain(10'd12, "t6b");
        chk("t6 vld after", BSK_W'(ntt_vld), '0);
        tick();
        tick();
        tick();
        chk("t6 vld stays low", BSK_W'(ntt_vld), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
